// File: rtl/agv_axil_master.sv
// AXI4-Lite single-access initiator: one command in, one AXI-Lite transaction out, one response strobe.
// Optional watchdog abort is compiled in with `define AGV_AXIL_TIMEOUT_EN.
`timescale 1ns/1ps
module agv_axil_master #(
  parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_aresetn,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                                rsp_valid,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                busy,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready
);

  localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;
  localparam int unsigned SW = C_M00_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StWr, StWrResp, StRdAddr, StRdData} state_e;

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            accept, b_hs, r_hs, timeout;

  assign accept = cmd_valid && cmd_ready_q;
  assign b_hs   = m00_axi_bvalid && bready_q;
  assign r_hs   = m00_axi_rvalid && rready_q;

`ifdef AGV_AXIL_TIMEOUT_EN
  logic [15:0] wd_q, wd_d, wd_inc;

  assign wd_inc  = wd_q + 16'd1;
  assign timeout = (state_q != StIdle) && (wd_inc == 16'hFFFF);

  always_comb begin
    wd_d = wd_q;
    if (accept) begin
      wd_d = '0;
    end else if (state_q != StIdle) begin
      wd_d = wd_inc;
    end
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = cmd_write ? StWr : StRdAddr;
      // A channel counts as done once its valid has dropped or is being accepted now.
      StWr:     if ((!awvalid_q || m00_axi_awready) && (!wvalid_q || m00_axi_wready)) begin
                  state_d = StWrResp;
                end
      StWrResp: if (b_hs) state_d = StIdle;
      StRdAddr: if (m00_axi_arready) state_d = StRdData;
      StRdData: if (r_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  always_comb begin
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end
        end
      end
      StWr: begin
        awvalid_d = awvalid_q && !m00_axi_awready;
        wvalid_d  = wvalid_q && !m00_axi_wready;
      end
      StWrResp: begin
        if (b_hs) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m00_axi_bresp;
        end
      end
      StRdData: begin
        if (r_hs) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m00_axi_rdata;
          rsp_resp_d  = m00_axi_rresp;
        end
      end
      default: ;
    endcase
    if (timeout) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_resp_d  = 2'b11;
      rsp_rdata_d = DW'(32'hDEAD_BEEF);
    end
    arvalid_d   = (state_d == StRdAddr);
    bready_d    = (state_d == StWrResp);
    rready_d    = (state_d == StRdData);
    // Hold off new commands during the response cycle so the caller sees the result first.
    cmd_ready_d = (state_d == StIdle) && !rsp_valid_d;
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = (state_q != StIdle);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = wstrb_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = bready_q;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = rready_q;

endmodule

// File: tb/tb_agv_axil_master.sv
// Bench for agv_axil_master: behavioural AXI-Lite slave, response scoreboard, scenario tasks.
`timescale 1ns/1ps
module tb_agv_axil_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  agv_axil_master #(
    .C_M00_AXI_DATA_WIDTH(32),
    .C_M00_AXI_ADDR_WIDTH(4)
  ) dut (
    .m00_axi_aclk   (clk),
    .m00_axi_aresetn(rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_wstrb      (cmd_wstrb),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .busy           (busy),
    .m00_axi_awaddr (awaddr),
    .m00_axi_awprot (awprot),
    .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata  (wdata),
    .m00_axi_wstrb  (wstrb),
    .m00_axi_wvalid (wvalid),
    .m00_axi_wready (wready),
    .m00_axi_bresp  (bresp),
    .m00_axi_bvalid (bvalid),
    .m00_axi_bready (bready),
    .m00_axi_araddr (araddr),
    .m00_axi_arprot (arprot),
    .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready),
    .m00_axi_rdata  (rdata),
    .m00_axi_rresp  (rresp),
    .m00_axi_rvalid (rvalid),
    .m00_axi_rready (rready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave configuration and observations.
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit          ar_never = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic [3:0]  last_awaddr, last_araddr, last_wstrb;
  logic [31:0] last_wdata;

  // Scoreboard of {rdata, resp} and monitor counters.
  logic [33:0] exp_q[$];
  int          n_rsp = 0, n_awv = 0, n_wv = 0, n_arv = 0, n_brd = 0, n_bhs = 0, n_acc = 0;
  int unsigned rsp_cyc = 0;
  logic        rsp_cmd_ready;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write slave: AW and W accepted independently, then one B beat.
  initial begin
    logic hs;
    int   t;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      wait (awvalid === 1'b1);
      #1;
      fork
        begin
          cyc(aw_delay); awready = 1'b1; last_awaddr = awaddr; cyc(1); awready = 1'b0;
        end
        begin
          cyc(w_delay); wready = 1'b1; last_wdata = wdata; last_wstrb = wstrb; cyc(1);
          wready = 1'b0;
        end
      join
      cyc(b_delay);
      bvalid = 1'b1; bresp = bresp_cfg; t = 0;
      do begin
        hs = bready; cyc(1); t++;
      end while (!hs && t < 40);
      bvalid = 1'b0;
    end
  end

  // Read slave.
  initial begin
    logic hs;
    int   t;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      wait (arvalid === 1'b1);
      #1;
      if (ar_never) begin
        wait (arvalid === 1'b0);
      end else begin
        cyc(ar_delay); arready = 1'b1; last_araddr = araddr; cyc(1); arready = 1'b0;
        cyc(r_delay);
        rvalid = 1'b1; rdata = rdata_cfg; rresp = rresp_cfg; t = 0;
        do begin
          hs = rready; cyc(1); t++;
        end while (!hs && t < 40);
        rvalid = 1'b0;
      end
    end
  end

  // Monitor and scoreboard pop, sampled mid-cycle.
  initial begin
    logic [33:0] exp;
    forever begin
      @(negedge clk);
      if (awvalid === 1'b1) n_awv++;
      if (wvalid === 1'b1) n_wv++;
      if (arvalid === 1'b1) n_arv++;
      if (bready === 1'b1) n_brd++;
      if (bvalid === 1'b1 && bready === 1'b1) n_bhs++;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) n_acc++;
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        rsp_cyc = cyc_cnt;
        rsp_cmd_ready = cmd_ready;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rsp_unexpected: got rdata=%h resp=%0d, required no response",
                   rsp_rdata, rsp_resp);
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_rdata, rsp_resp} !== exp) begin
            $display("FAIL rsp_scoreboard: got rdata=%h resp=%0d, required rdata=%h resp=%0d",
                     rsp_rdata, rsp_resp, exp[33:2], exp[1:0]);
          end else begin
            n_pass++;
          end
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, output int unsigned acc);
    int t;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      cyc(1); t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1 within 100 cycles", cmd_ready);
    end
    acc = cyc_cnt;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int bound);
    int t;
    t = 0;
    while (n_rsp < target && t < bound) begin
      cyc(1); t++;
    end
    if (n_rsp < target) begin
      n_checks++;
      $display("FAIL rsp_wait_timeout: responses=%0d, required %0d", n_rsp, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    #20;
    n_checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid, busy} !== 8'h00) begin
      $display("FAIL reset_ctrl: valids/readies=%b, required 00000000",
               {awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid, busy});
    end else n_pass++;
    n_checks++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, awprot, arprot} !== '0) begin
      $display("FAIL reset_data: awaddr=%h wdata=%h wstrb=%h rsp_rdata=%h rsp_resp=%0d, required 0",
               awaddr, wdata, wstrb, rsp_rdata, rsp_resp);
    end else n_pass++;
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
    end else n_pass++;
    cyc(5);
    n_checks++;
    if (n_rsp != 0 || {awvalid, wvalid, arvalid} !== 3'b000) begin
      $display("FAIL reset_idle: responses=%0d valids=%b, required 0/000",
               n_rsp, {awvalid, wvalid, arvalid});
    end else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    int unsigned acc;
    int          base, bhs0;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    base = n_rsp; bhs0 = n_bhs;
    exp_q.push_back({32'h0, 2'b00});
    issue(1'b1, 4'h0, 32'h0756_0000, 4'hF, acc);
    wait_rsp(base + 1, 50);
    n_checks++;
    if (last_awaddr !== 4'h0 || last_wdata !== 32'h0756_0000 || last_wstrb !== 4'hF) begin
      $display("FAIL wr_channels: awaddr=%h wdata=%h wstrb=%h, required 0/07560000/f",
               last_awaddr, last_wdata, last_wstrb);
    end else n_pass++;
    n_checks++;
    if (int'(rsp_cyc - acc) != 3) begin
      $display("FAIL wr_latency: got %0d cycles, required 3", int'(rsp_cyc - acc));
    end else n_pass++;
    n_checks++;
    if (n_bhs - bhs0 != 1) begin
      $display("FAIL wr_b_handshakes: got %0d, required 1", n_bhs - bhs0);
    end else n_pass++;
  endtask

  task automatic test_write_wready_delay();
    int unsigned acc;
    int          base;
    aw_delay = 0; w_delay = 5; bresp_cfg = 2'b00;
    base = n_rsp; n_awv = 0; n_wv = 0; n_bhs = 0;
    exp_q.push_back({32'h0, 2'b00});
    issue(1'b1, 4'h4, 32'hA5A5_0001, 4'h3, acc);
    cyc(1);
    n_checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b1) begin
      $display("FAIL wr_split_valids: awvalid=%b wvalid=%b, required 0/1", awvalid, wvalid);
    end else n_pass++;
    wait_rsp(base + 1, 60);
    cyc(5);
    n_checks++;
    if (n_awv != 1 || n_wv != 6) begin
      $display("FAIL wr_valid_cycles: aw=%0d w=%0d, required 1/6", n_awv, n_wv);
    end else n_pass++;
    n_checks++;
    if (n_bhs != 1 || n_rsp - base != 1) begin
      $display("FAIL wr_single_resp: b_hs=%0d rsp=%0d, required 1/1", n_bhs, n_rsp - base);
    end else n_pass++;
    n_checks++;
    if (last_wdata !== 32'hA5A5_0001 || last_wstrb !== 4'h3 || last_awaddr !== 4'h4) begin
      $display("FAIL wr_held_data: awaddr=%h wdata=%h wstrb=%h, required 4/a5a50001/3",
               last_awaddr, last_wdata, last_wstrb);
    end else n_pass++;
    w_delay = 0;
  endtask

  task automatic test_read_delay();
    int unsigned acc;
    int          base;
    ar_delay = 0; r_delay = 4; rdata_cfg = 32'h0000_0756; rresp_cfg = 2'b00;
    base = n_rsp;
    exp_q.push_back({32'h0000_0756, 2'b00});
    issue(1'b0, 4'h0, 32'h0, 4'h0, acc);
    wait_rsp(base + 1, 60);
    n_checks++;
    if (rsp_cmd_ready !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL rd_cmd_ready: during rsp=%b after=%b, required 0/1", rsp_cmd_ready, cmd_ready);
    end else n_pass++;
    n_checks++;
    if (rsp_rdata !== 32'h0000_0756 || last_araddr !== 4'h0) begin
      $display("FAIL rd_hold: rsp_rdata=%h araddr=%h, required 00000756/0", rsp_rdata, last_araddr);
    end else n_pass++;
    n_checks++;
    if (int'(rsp_cyc - acc) != 7) begin
      $display("FAIL rd_latency: got %0d cycles, required 7", int'(rsp_cyc - acc));
    end else n_pass++;
    r_delay = 0;
  endtask

  task automatic test_error_resp();
    int unsigned acc;
    int          base;
    rdata_cfg = 32'h1234_ABCD; rresp_cfg = 2'b10;
    base = n_rsp;
    exp_q.push_back({32'h1234_ABCD, 2'b10});
    issue(1'b0, 4'hC, 32'h0, 4'h0, acc);
    wait_rsp(base + 1, 50);
    cyc(5);
    n_checks++;
    if (n_rsp - base != 1 || last_araddr !== 4'hC) begin
      $display("FAIL rd_err_single: rsp=%0d araddr=%h, required 1/c", n_rsp - base, last_araddr);
    end else n_pass++;
    rresp_cfg = 2'b00; bresp_cfg = 2'b11;
    exp_q.push_back({32'h0, 2'b11});
    issue(1'b1, 4'h8, 32'hCAFE_F00D, 4'h1, acc);
    wait_rsp(base + 2, 50);
    cyc(3);
    n_checks++;
    if (rsp_resp !== 2'b11 || rsp_rdata !== 32'h0) begin
      $display("FAIL wr_err_hold: rsp_resp=%0d rsp_rdata=%h, required 3/0", rsp_resp, rsp_rdata);
    end else n_pass++;
    bresp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back();
    int base, acc0;
    rdata_cfg = 32'h0BAD_F00D;
    base = n_rsp; acc0 = n_acc;
    exp_q.push_back({32'h0BAD_F00D, 2'b00});
    exp_q.push_back({32'h0BAD_F00D, 2'b00});
    cmd_write = 1'b0; cmd_addr = 4'h8; cmd_valid = 1'b1;
    wait_rsp(base + 2, 60);
    cmd_valid = 1'b0;
    cyc(3);
    n_checks++;
    if (n_acc - acc0 != 2 || n_rsp - base != 2) begin
      $display("FAIL b2b_accepts: accepts=%0d rsp=%0d, required 2/2", n_acc - acc0, n_rsp - base);
    end else n_pass++;
  endtask

`ifdef AGV_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned acc;
    int          base;
    ar_never = 1'b1; base = n_rsp; n_arv = 0;
    exp_q.push_back({32'hDEAD_BEEF, 2'b11});
    issue(1'b0, 4'h4, 32'h0, 4'h0, acc);
    wait_rsp(base + 1, 70000);
    n_checks++;
    if (n_arv != 65535 || busy !== 1'b0 || arvalid !== 1'b0) begin
      $display("FAIL timeout_abort: arvalid cycles=%0d busy=%b arvalid=%b, required 65535/0/0",
               n_arv, busy, arvalid);
    end else n_pass++;
    ar_never = 1'b0;
    cyc(2);
  endtask
`endif

  task automatic test_reset_mid_wr();
    int unsigned acc;
    int          base;
    aw_delay = 8; w_delay = 8;
    issue(1'b1, 4'h8, 32'h1111_2222, 4'hF, acc);
    cyc(1);
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      $display("FAIL midwr_pre: awvalid=%b wvalid=%b, required 1/1", awvalid, wvalid);
    end else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({awvalid, wvalid, bready, busy} !== 4'b0000) begin
      $display("FAIL midwr_async_drop: aw/w/bready/busy=%b, required 0000",
               {awvalid, wvalid, bready, busy});
    end else n_pass++;
    cyc(2);
    rst_n = 1'b1;
    base = n_rsp; n_brd = 0;
    cyc(60);
    n_checks++;
    if (n_brd != 0 || n_rsp != base || exp_q.size() != 0) begin
      $display("FAIL midwr_ignored: bready cycles=%0d rsp=%0d pending=%0d, required 0/0/0",
               n_brd, n_rsp - base, exp_q.size());
    end else n_pass++;
    aw_delay = 0; w_delay = 0;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_wready_delay();
    test_read_delay();
    test_error_resp();
    test_back_to_back();
`ifdef AGV_AXIL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
